// File: rtl/lcb_responder_if.sv
// Bus bundle for the LCB responder: incoming request bytes, register-file
// read port and the RS485 line/direction outputs.
interface lcb_responder_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [4:0] rd_addr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       tx;
    logic       dirTX;
    logic       dirRX;
    logic       busy;
    logic       req_err;

    modport slave (
        input  rx_valid, rx_data, rd_data,
        output rd_addr, rd_en, tx, dirTX, dirRX, busy, req_err
    );

    modport master (
        output rx_valid, rx_data, rd_data,
        input  rd_addr, rd_en, tx, dirTX, dirRX, busy, req_err
    );
endinterface

// File: rtl/lcb_responder.sv
// LCB endpoint of the M16 polling link: decodes a 4-byte request and answers
// with tag + register bytes over 8N1. Define LCB_RESP_CHECKSUM_EN to append an XOR byte.
//
//   state   | meaning
//   S_IDLE  | collecting request bytes, line released
//   S_TURN  | driver enabled, idle-high turnaround
//   S_SEND  | shifting one 10-bit character
//   S_LOAD  | register-file read issued (inside stop bit)
//   S_CAPT  | read data captured into the shifter (inside stop bit)
//   S_GUARD | one idle bit period before releasing the bus
module lcb_responder #(
    parameter logic [7:0] DEV_ADDR  = 8'h01,
    parameter int         REQ_BYTES = 4,
    parameter int         CLK_DIV   = 16,
    parameter int         RESP_MAX  = 16,
    parameter int         TIMEOUT   = 2000,
    parameter int         TURN_BITS = 2
) (
    input logic            clk,
    input logic            rst,
    lcb_responder_if.slave bus
);

    localparam int TURN_CYC = TURN_BITS * CLK_DIV;
    localparam int TMR_MAX  = (TURN_CYC > CLK_DIV) ? TURN_CYC : CLK_DIV;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int IDX_W    = $clog2(REQ_BYTES);
    localparam int TO_W     = $clog2(TIMEOUT + 1);

    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TURN_LAST = TMR_W'(TURN_CYC - 1);
    localparam logic [TMR_W-1:0] LOAD_AT   = TMR_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_SEND,
        S_LOAD,
        S_CAPT,
        S_GUARD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_buf [REQ_BYTES];
    logic [IDX_W-1:0] r_idx;
    logic [TO_W-1:0]  r_to_cnt;
    logic [TMR_W-1:0] r_tmr;
    logic [3:0]       r_bit;
    logic [9:0]       r_shift;
    logic [4:0]       r_start;
    logic [7:0]       r_len;
    logic [7:0]       r_k;
    logic             r_req_err;
`ifdef LCB_RESP_CHECKSUM_EN
    logic [7:0]       r_chk;
    logic             r_chk_done;
`endif

    logic w_rx;
    logic w_last_byte;
    logic w_hit;
    logic w_range_bad;
    logic w_accept;
    logic w_bad;
    logic w_more;
    logic w_rd_en;

    assign w_rx        = (r_state == S_IDLE) && bus.rx_valid;
    assign w_last_byte = w_rx && (r_idx == IDX_W'(REQ_BYTES - 1));
    assign w_hit       = w_last_byte && (r_buf[0] == DEV_ADDR);
    // The length byte is still on rx_data when the frame completes.
    assign w_range_bad = (bus.rx_data == 8'd0)
                      || ({1'b0, bus.rx_data} > 9'(RESP_MAX))
                      || (({4'd0, r_buf[2][4:0]} + {1'b0, bus.rx_data}) > 9'd32);
    assign w_accept    = w_hit && !w_range_bad;
    assign w_bad       = w_hit && w_range_bad;

`ifdef LCB_RESP_CHECKSUM_EN
    assign w_more = (r_k != r_len) || !r_chk_done;
`else
    assign w_more = (r_k != r_len);
`endif

    assign w_rd_en     = (r_state == S_LOAD) && (r_k != r_len);
    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = w_rd_en ? (r_start + r_k[4:0]) : 5'd0;
    assign bus.tx      = (r_state == S_SEND) ? r_shift[0] : 1'b1;
    assign bus.dirTX   = (r_state != S_IDLE);
    assign bus.dirRX   = (r_state != S_IDLE);
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.req_err = r_req_err;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_TURN;
            S_TURN:  if (r_tmr == '0) w_state_nxt = S_SEND;
            S_SEND: begin
                if (r_bit == 4'd9) begin
                    if (w_more && (r_tmr == LOAD_AT))
                        w_state_nxt = S_LOAD;
                    else if (!w_more && (r_tmr == '0))
                        w_state_nxt = S_GUARD;
                end
            end
            S_LOAD:  w_state_nxt = S_CAPT;
            S_CAPT:  w_state_nxt = S_SEND;
            S_GUARD: if (r_tmr == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rx)
            r_buf[r_idx] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_to_cnt   <= '0;
            r_tmr      <= '0;
            r_bit      <= '0;
            r_shift    <= '1;
            r_start    <= '0;
            r_len      <= '0;
            r_k        <= '0;
            r_req_err  <= 1'b0;
`ifdef LCB_RESP_CHECKSUM_EN
            r_chk      <= '0;
            r_chk_done <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_req_err <= w_bad;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        r_to_cnt <= '0;
                        r_idx    <= w_last_byte ? '0 : r_idx + 1'b1;
                    end else if (r_idx != '0) begin
                        if (r_to_cnt == TO_W'(TIMEOUT)) begin
                            r_idx    <= '0;
                            r_to_cnt <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end else begin
                        r_to_cnt <= '0;
                    end
                    if (w_accept) begin
                        r_tmr      <= TURN_LAST;
                        r_bit      <= '0;
                        r_shift    <= {1'b1, r_buf[1], 1'b0};
                        r_start    <= r_buf[2][4:0];
                        r_len      <= bus.rx_data;
                        r_k        <= '0;
`ifdef LCB_RESP_CHECKSUM_EN
                        r_chk      <= r_buf[1];
                        r_chk_done <= 1'b0;
`endif
                    end
                end
                S_TURN: r_tmr <= (r_tmr == '0) ? BIT_LAST : r_tmr - 1'b1;
                S_SEND: begin
                    if (r_bit == 4'd9) begin
                        r_tmr <= (w_state_nxt == S_GUARD) ? BIT_LAST : r_tmr - 1'b1;
                    end else if (r_tmr == '0) begin
                        r_tmr   <= BIT_LAST;
                        r_bit   <= r_bit + 1'b1;
                        r_shift <= {1'b1, r_shift[9:1]};
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_LOAD: r_tmr <= BIT_LAST;
                S_CAPT: begin
                    r_tmr <= BIT_LAST;
                    r_bit <= '0;
`ifdef LCB_RESP_CHECKSUM_EN
                    if (r_k != r_len) begin
                        r_shift <= {1'b1, bus.rd_data, 1'b0};
                        r_k     <= r_k + 1'b1;
                        r_chk   <= r_chk ^ bus.rd_data;
                    end else begin
                        r_shift    <= {1'b1, r_chk, 1'b0};
                        r_chk_done <= 1'b1;
                    end
`else
                    r_shift <= {1'b1, bus.rd_data, 1'b0};
                    r_k     <= r_k + 1'b1;
`endif
                end
                S_GUARD: if (r_tmr != '0) r_tmr <= r_tmr - 1'b1;
                default: r_tmr <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lcb_responder.sv
// Bench for lcb_responder: frame-level model predicts the exact line waveform
// and read addresses; a UART decoder recovers the response bytes.
module tb_lcb_responder;
    localparam int         CLK_DIV   = 16;
    localparam int         TURN_BITS = 2;
    localparam int         TIMEOUT   = 2000;
    localparam int         RESP_MAX  = 16;
    localparam logic [7:0] DEV       = 8'h01;
`ifdef LCB_RESP_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    lcb_responder_if bus();

    lcb_responder #(
        .DEV_ADDR(DEV), .REQ_BYTES(4), .CLK_DIV(CLK_DIV),
        .RESP_MAX(RESP_MAX), .TIMEOUT(TIMEOUT), .TURN_BITS(TURN_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] mem [32];

    bit [1:0]   exp_q [$];
    logic [4:0] addr_q [$];
    int         m_idx = 0;
    logic [7:0] m_buf [4];
    int         m_last = 0;
    bit         m_prev_busy = 0;
    bit         m_err_exp = 0;
    bit         chk_on = 0;

    logic [7:0] dec_q [$];
    logic [7:0] dec_byte;
    bit         dec_on = 0;
    int         dec_t = 0;
    int         dir_cnt = 0, err_cnt = 0, rd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected response for a completed 4-byte frame, from the link rules only.
    task automatic model_frame();
        logic [7:0] rb [$];
        logic [7:0] x;
        bit         v;
        int         st, ln;
        st = int'(m_buf[2][4:0]);
        ln = int'(m_buf[3]);
        if (m_buf[0] != DEV) return;
        if (ln == 0 || ln > RESP_MAX || st + ln > 32) begin
            m_err_exp = 1;
            return;
        end
        rb.push_back(m_buf[1]);
        x = m_buf[1];
        for (int k = 0; k < ln; k++) begin
            rb.push_back(mem[st + k]);
            x ^= mem[st + k];
            addr_q.push_back(5'(st + k));
        end
        if (CHK != 0) rb.push_back(x);
        repeat (TURN_BITS * CLK_DIV) exp_q.push_back(2'b11);
        foreach (rb[b]) begin
            for (int j = 0; j < 10; j++) begin
                v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : rb[b][j-1];
                repeat (CLK_DIV) exp_q.push_back({v, 1'b1});
            end
        end
        repeat (CLK_DIV) exp_q.push_back(2'b11);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
            m_idx = 0;
            m_prev_busy = 0;
            m_err_exp = 0;
            chk_on = 1;
        end else begin
            m_err_exp = 0;
            if (bus.rx_valid && !m_prev_busy) begin
                if (m_idx != 0 && cyc - m_last > TIMEOUT + 1) m_idx = 0;
                m_buf[m_idx] = bus.rx_data;
                m_idx++;
                m_last = cyc;
                if (m_idx == 4) begin
                    m_idx = 0;
                    model_frame();
                end
            end
        end
    end

    always @(posedge clk)
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        bit [1:0] e;
        if (chk_on) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b10;
            chk("tx", bus.tx, e[1]);
            chk("dirTX", bus.dirTX, e[0]);
            chk("dirRX", bus.dirRX, e[0]);
            chk("busy", bus.busy, e[0]);
            chk("req_err", bus.req_err, m_err_exp);
            m_prev_busy = e[0];
            if (bus.rd_en) begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_en: got unexpected read at addr %0h (cycle %0d)", bus.rd_addr, cyc);
                end else begin
                    chk("rd_addr", bus.rd_addr, addr_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.dirTX) dir_cnt++;
        if (bus.req_err) err_cnt++;
        if (bus.rd_en) rd_cnt++;
        if (!bus.dirTX) begin
            dec_on = 0;
        end else if (!dec_on) begin
            if (bus.tx == 1'b0) begin
                dec_on = 1;
                dec_t = 0;
            end
        end else begin
            dec_t++;
            if (dec_t % CLK_DIV == CLK_DIV / 2) begin
                if (dec_t / CLK_DIV >= 1 && dec_t / CLK_DIV <= 8)
                    dec_byte[dec_t / CLK_DIV - 1] = bus.tx;
                else if (dec_t / CLK_DIV == 9) begin
                    dec_q.push_back(dec_byte);
                    dec_on = 0;
                end
            end
        end
    end

    task automatic clr();
        @(posedge clk);
        dec_q.delete();
        dir_cnt = 0;
        err_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0, 0);
        send_byte(b1, 0);
        send_byte(b2, 0);
        send_byte(b3, 0);
    endtask

    task automatic wait_idle(input string nm);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || bus.dirTX) && i < 6000) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        chk({nm, "_released"}, bus.dirTX, 1'b0);
        chk({nm, "_reads_done"}, addr_q.size(), 0);
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit [6];
        logic [7:0] bad [3][4];
        logic [7:0] a, t;
        int         st, ln, r, i;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rd_data  = 8'h00;
        for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_dirTX", bus.dirTX, 1'b0);
        chk("rst_dirRX", bus.dirRX, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_req_err", bus.req_err, 1'b0);
        chk("rst_rd_en", bus.rd_en, 1'b0);
        chk("rst_rd_addr", bus.rd_addr, 5'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Valid request.
        mem[3] = 8'h11; mem[4] = 8'h22; mem[5] = 8'h33; mem[6] = 8'h44;
        lit = '{8'h2A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h6E};
        clr();
        send_frame(8'h01, 8'h2A, 8'h03, 8'h04);
        chk("t1_dir_rise", bus.dirTX, 1'b1);
        wait_idle("t1");
        chk("t1_nbytes", dec_q.size(), 5 + CHK);
        for (int k = 0; k < 5 + CHK; k++) chk("t1_byte", dec_q[k], lit[k]);
        chk("t1_dir_cycles", dir_cnt, (CHK != 0) ? 1008 : 848);
        chk("t1_reads", rd_cnt, 4);

        // Wrong address, then a correctly addressed frame.
        clr();
        send_frame(8'h05, 8'h2A, 8'h03, 8'h04);
        repeat (100) @(negedge clk);
        chk("t2_err", err_cnt, 0);
        chk("t2_dir", dir_cnt, 0);
        chk("t2_bytes", dec_q.size(), 0);
        send_frame(8'h01, 8'h2A, 8'h03, 8'h04);
        wait_idle("t2b");
        chk("t2b_bytes", dec_q.size(), 5 + CHK);

        // Malformed addressed requests.
        bad = '{'{8'h01, 8'h00, 8'h1E, 8'h04}, '{8'h01, 8'h00, 8'h00, 8'h00},
                '{8'h01, 8'h00, 8'h00, 8'h11}};
        for (int f = 0; f < 3; f++) begin
            clr();
            send_frame(bad[f][0], bad[f][1], bad[f][2], bad[f][3]);
            repeat (40) @(negedge clk);
            chk("t3_err_pulses", err_cnt, 1);
            chk("t3_dir", dir_cnt, 0);
        end

        // Inter-byte timeout discards the partial frame.
        mem[0] = 8'hC3;
        clr();
        send_byte(8'h01, 0);
        send_byte(8'h2A, 0);
        repeat (TIMEOUT + 3) @(negedge clk);
        send_frame(8'h01, 8'h07, 8'h00, 8'h01);
        wait_idle("t4");
        chk("t4_nbytes", dec_q.size(), 2 + CHK);
        chk("t4_tag", dec_q[0], 8'h07);
        chk("t4_data", dec_q[1], 8'hC3);

        // Reset during the third data byte; stray bytes during the response.
        clr();
        send_frame(8'h01, 8'h33, 8'h00, 8'h08);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04);
        i = 0;
        while (dec_q.size() < 3 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("t5_reach", dec_q.size(), 3);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_tx", bus.tx, 1'b1);
        chk("t5_dirTX", bus.dirTX, 1'b0);
        chk("t5_busy", bus.busy, 1'b0);
        rst = 1'b0;
        clr();
        send_frame(8'h01, 8'h44, 8'h05, 8'h02);
        wait_idle("t5b");
        chk("t5b_nbytes", dec_q.size(), 3 + CHK);
        chk("t5b_tag", dec_q[0], 8'h44);

        // Maximum length.
        clr();
        send_frame(8'h01, 8'h55, 8'h10, 8'h10);
        wait_idle("t6");
        chk("t6_reads", rd_cnt, 16);
        chk("t6_nbytes", dec_q.size(), 17 + CHK);
        chk("t6_tag", dec_q[0], 8'h55);

        // Randomized frames.
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(2, 255)) : DEV;
            t  = 8'($urandom);
            st = $urandom_range(0, 31);
            r  = $urandom_range(0, 9);
            ln = (r < 7) ? $urandom_range(1, 8) : (r == 7) ? 0 : $urandom_range(9, 20);
            clr();
            send_byte(a, $urandom_range(0, 3));
            send_byte(t, $urandom_range(0, 3));
            send_byte(8'(st), $urandom_range(0, 3));
            send_byte(8'(ln), 0);
            repeat ($urandom_range(1, 200)) @(negedge clk);
            if (exp_q.size() > 2 * CLK_DIV) send_byte(8'($urandom), 0);
            wait_idle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
